data_mem_responder: RTL

Memory-side responder for the pipeline's data-memory port: accepts one load/store request at a time over a valid/ready handshake and services it after a fixed, parameterised latency. Word, halfword and byte stores use byte-lane writes. Loads return data sign-extended to 32 bits. The MEM stage is held through `Stall` while a request is outstanding, so a multi-cycle memory can replace the single-cycle data memory without changing the load/store semantics.

---
 rtl/data_mem_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with fixed latency,
// byte-lane stores, sign-extended loads and a Stall output for the MEM stage.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        RespErr,
    output logic        Stall
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept, w_do, w_write, w_err;
    logic [1:0]  w_size;
    logic [31:0] w_addr, w_wdata, w_word, w_lane_data, w_rdata;
    logic [3:0]  w_be;
    logic [AW-1:0] w_idx;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (w_accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                 r_state == WAIT ? (r_cnt == CW'(1) ? RESP : WAIT) : IDLE;
    end

    always_comb begin
        ReqReady  = r_state == IDLE;
        Stall     = r_state != IDLE;
        RespValid = r_state == RESP;
    end

    assign w_accept = ReqValid & ReqReady;
    // With LATENCY = 1 the service edge is the accept edge itself, so use the live request.
    assign w_do     = LATENCY == 1 ? w_accept : (r_state == WAIT && r_cnt == CW'(1));
    assign w_write  = r_state == IDLE ? ReqWrite : r_write;
    assign w_size   = r_state == IDLE ? ReqSize  : r_size;
    assign w_addr   = r_state == IDLE ? ReqAddr  : r_addr;
    assign w_wdata  = r_state == IDLE ? ReqWData : r_wdata;

    assign w_err = w_size == 2'b11 || (w_size == 2'b00 && w_addr[1:0] != 2'b00) ||
                   (w_size == 2'b01 && w_addr[0]) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
    assign w_idx  = w_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_be   = w_size == 2'b00 ? 4'hf : w_size == 2'b01 ? (w_addr[1] ? 4'hc : 4'h3) :
                    4'b0001 << w_addr[1:0];
    assign w_lane_data = w_size == 2'b00 ? w_wdata : w_size == 2'b01 ? {2{w_wdata[15:0]}} :
                         {4{w_wdata[7:0]}};
    assign w_rdata = (w_write || w_err) ? 32'h0 : w_size == 2'b00 ? w_word :
                     w_size == 2'b01 ? {{16{w_half[15]}}, w_half} : {{24{w_byte[7]}}, w_byte};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= CW'(LATENCY - 1);
            r_write <= ReqWrite;
            r_size  <= ReqSize;
            r_addr  <= ReqAddr;
            r_wdata <= ReqWData;
        end else if (r_state == WAIT) begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            RespRData <= '0;
            RespErr   <= 1'b0;
        end else if (w_do) begin
            RespRData <= w_rdata;
            RespErr   <= w_err;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do && w_write && !w_err) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
        end
    end
endmodule
